piso_frame_serializer: RTL and testbench
========================================

// Module: piso_frame_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out framed transmitter; successor to the 8-bit PISO shift register.
//  Accepts a DATA_WIDTH word over a valid/ready handshake and emits one UART-style frame:
//  start bit, data bits (LSB- or MSB-first), optional parity, STOP_BITS stop bits.
//  Sits between the audio sample source and the serial line driver; the line idles high.
// PARAMETERS
//  DATA_WIDTH   8   bits per word, 1..32
//  CLK_DIV      16  CLOCK_50 cycles per serial bit, >=1
//  STOP_BITS    1   stop bits per frame, 1..2
//  MSB_FIRST    0   0: bit 0 sent first; 1: bit DATA_WIDTH-1 sent first
//  PARITY_EN    0   1: append parity bit after data
//  PARITY_ODD   0   0: even parity; 1: odd parity (ignored when PARITY_EN=0)
// PORTS
//  CLOCK_50    in   1           system clock; all logic on posedge
//  Reset       in   1           synchronous, active-high
//  Tx_Data     in   DATA_WIDTH  word to send; sampled only on accept
//  Tx_Valid    in   1           word available
//  Tx_Ready    out  1           block can accept; accept = Tx_Valid & Tx_Ready at posedge
//  Serial_Out  out  1           serial line, registered, idle high
//  Busy        out  1           frame in progress (start through last stop bit)
//  Bit_Strobe  out  1           one-cycle pulse on the last cycle of each bit period
// BEHAVIOUR
//  - Reset values: Serial_Out=1, Busy=0, Bit_Strobe=0, state=IDLE, counters=0, shift reg=all 1s.
//  - Tx_Ready = ~Reset & (state==IDLE | (state==STOP & last stop bit & div_cnt==CLK_DIV-1)).
//  - FSM: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE, or -> START on accept.
//  - Accept at edge N: Tx_Data and its parity are latched; from edge N, Serial_Out=0 (start bit).
//    It is visible in cycle N+1. Busy=1 in the same cycle.
//  - Each bit is held exactly CLK_DIV cycles. div_cnt counts 0..CLK_DIV-1, width $clog2(CLK_DIV)+1.
//    Bit_Strobe=1 when div_cnt==CLK_DIV-1.
//  - DATA: bit_cnt counts 0..DATA_WIDTH-1. The shift register shifts toward the output end.
//    Vacated positions fill with 1.
//  - Parity: even gives ^data; odd gives ~^data. It is computed at accept, not from the shifting register.
//  - STOP: Serial_Out=1 for STOP_BITS*CLK_DIV cycles.
//  - Frame length F = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLK_DIV cycles.
//  - Back-to-back: if Tx_Valid is high in the final stop cycle, the next start bit follows with no gap.
//    Throughput is then one frame per F cycles.
//  - Otherwise the block returns to IDLE with Serial_Out=1 and Busy=0.
//  - Tx_Data changes while Busy are ignored. Tx_Valid without Tx_Ready has no effect.
//  - Reset mid-frame: abort at that edge. Serial_Out=1 from the next cycle, and nothing is accepted
//    while Reset is high.
//  - Reset and Tx_Valid together: Reset wins, and the word is dropped.
//  - CLK_DIV=1: one bit per cycle; Bit_Strobe is continuously high while Busy.
// STRUCTURE
//  - Shared package serial_tx_pkg: state encoding (IDLE, START, DATA, PARITY, STOP).
//    It also holds the line levels LINE_IDLE=1 and START_LEVEL=0, and the frame-length function.
//    The future receiver reuses this package.
//  - Sub-module bit_period_counter: divides CLOCK_50 by CLK_DIV.
//    It has a sync clear on frame start/Reset and outputs the Bit_Strobe pulse.
//  - Top: FSM, bit_cnt, stop_cnt, shift register, parity register, output register.
// TESTING
//  1. Reset, DATA_WIDTH=8, CLK_DIV=4, LSB-first, Tx_Data=8'hA5 ->
//     line 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; Busy high for 40 cycles.
//  2. MSB_FIRST=1, PARITY_EN=1, even, 8'h07 ->
//     data 0,0,0,0,0,1,1,1, parity=1, stop=1; frame is 11*CLK_DIV cycles.
//  3. Tx_Valid held high with 8'h01 then 8'h80 -> second start bit follows last stop cycle directly.
//     Tx_Ready pulses exactly once per frame.
//  4. Reset asserted mid-DATA (bit 3) -> Serial_Out=1 the next cycle, Busy=0, Tx_Ready=1 after Reset falls.
//     A fresh 8'h3C then sends correctly.
//  5. CLK_DIV=1, STOP_BITS=2, DATA_WIDTH=12, 12'hFFF -> 15-cycle frame; Bit_Strobe high all 15 cycles.
//  6. Tx_Data toggled every cycle during a frame -> transmitted bits match only the word latched at accept.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmit/receive family: FSM encoding,
// line levels and the frame-length helper.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Clock cycles occupied by one complete frame, start bit through last stop bit.
  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned clk_div,
                                               input int unsigned stop_bits,
                                               input int unsigned parity_en);
    return (1 + data_width + parity_en + stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Divides the system clock by CLK_DIV and flags the last cycle of each serial
// bit period; a synchronous clear realigns the count at frame start.
module bit_period_counter #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic strobe
);

  localparam int CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CNT_W'(1);
    end
  end

  // Gated by enable so CLK_DIV=1 does not strobe while the line is idle.
  assign strobe = enable && (div_cnt == LAST);

endmodule

// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out framed transmitter: latches a word on a valid/ready
// handshake and sends start, data, optional parity and stop bits, line idles high.
module piso_frame_serializer
  import serial_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 16,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] Tx_Data,
  input  logic                  Tx_Valid,
  output logic                  Tx_Ready,
  output logic                  Serial_Out,
  output logic                  Busy,
  output logic                  Bit_Strobe
);

  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic                  LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [DATA_WIDTH-1:0] FILL_MSB  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  tx_state_t             state, next_state;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg, shreg_shift;
  logic                  parity_q;
  logic                  bit_strobe, accept, last_bit, last_stop, serial_next;

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
  endfunction

  assign last_bit   = (bit_cnt == LAST_BIT);
  assign last_stop  = (stop_cnt == LAST_STOP);
  assign Tx_Ready   = !Reset && ((state == ST_IDLE) ||
                                 (state == ST_STOP && last_stop && bit_strobe));
  assign accept     = Tx_Valid && Tx_Ready;
  assign Bit_Strobe = bit_strobe;

  bit_period_counter #(.CLK_DIV(CLK_DIV)) u_bit_period_counter (
    .clk    (CLOCK_50),
    .clear  (Reset || accept),
    .enable (Busy),
    .strobe (bit_strobe)
  );

  always_ff @(posedge CLOCK_50) begin
    if (Reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (accept) next_state = ST_START;
      ST_START:  if (bit_strobe) next_state = ST_DATA;
      ST_DATA:   if (bit_strobe && last_bit)
                   next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_strobe) next_state = ST_STOP;
      ST_STOP:   if (bit_strobe && last_stop)
                   next_state = accept ? ST_START : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Serial_Out is registered, so this selects the level of the bit that starts at the coming edge.
  always_comb begin
    Busy        = (state != ST_IDLE);
    shreg_shift = (MSB_FIRST != 0) ? ((shreg << 1) | DATA_WIDTH'(1))
                                   : ((shreg >> 1) | FILL_MSB);
    serial_next = Serial_Out;
    if (accept) begin
      serial_next = START_LEVEL;
    end else if (bit_strobe) begin
      unique case (state)
        ST_START: serial_next = out_bit(shreg);
        ST_DATA:  serial_next = last_bit ? ((PARITY_EN != 0) ? parity_q : LINE_IDLE)
                                         : out_bit(shreg_shift);
        default:  serial_next = LINE_IDLE;
      endcase
    end
  end

  // NOTE: the shift register has an explicit reset value (all ones) so a
  // reset can never leave stale data bits queued for the line.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      Serial_Out <= LINE_IDLE;
      shreg      <= '1;
      parity_q   <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      Serial_Out <= serial_next;
      if (accept) begin
        shreg    <= Tx_Data;
        parity_q <= (PARITY_ODD != 0) ? ~^Tx_Data : ^Tx_Data;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
      end else if (bit_strobe) begin
        if (state == ST_DATA) begin
          shreg   <= shreg_shift;
          bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
        end
        if (state == ST_STOP) begin
          stop_cnt <= last_stop ? 1'b0 : 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Self-checking bench: four serializer configurations checked cycle by cycle
// against a scoreboard of expected line level, Busy, Bit_Strobe and Tx_Ready.
module tb_piso_frame_serializer;

  localparam int NDUT = 4;
  localparam int P_DW  [NDUT] = '{8, 8, 12, 8};
  localparam int P_CD  [NDUT] = '{4, 4, 1, 2};
  localparam int P_SB  [NDUT] = '{1, 1, 2, 1};
  localparam int P_MSB [NDUT] = '{0, 1, 0, 0};
  localparam int P_PE  [NDUT] = '{0, 1, 0, 1};
  localparam int P_PO  [NDUT] = '{0, 0, 0, 1};

  typedef struct packed {
    logic serial;
    logic busy;
    logic strobe;
    logic ready;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      tx_data [NDUT];
  logic [NDUT-1:0]  tx_valid;
  logic [NDUT-1:0]  tx_ready, serial, busy, strobe;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    piso_frame_serializer #(
      .DATA_WIDTH (P_DW[g]),
      .CLK_DIV    (P_CD[g]),
      .STOP_BITS  (P_SB[g]),
      .MSB_FIRST  (P_MSB[g]),
      .PARITY_EN  (P_PE[g]),
      .PARITY_ODD (P_PO[g])
    ) u_dut (
      .CLOCK_50   (clk),
      .Reset      (rst),
      .Tx_Data    (tx_data[g][P_DW[g]-1:0]),
      .Tx_Valid   (tx_valid[g]),
      .Tx_Ready   (tx_ready[g]),
      .Serial_Out (serial[g]),
      .Busy       (busy[g]),
      .Bit_Strobe (strobe[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int flen(input int k);
    return (1 + P_DW[k] + P_PE[k] + P_SB[k]) * P_CD[k];
  endfunction

  // Model: one scoreboard entry per clock cycle of the frame.
  task automatic push_frame(input int k, input logic [31:0] d);
    logic bits[$];
    logic p;
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < P_DW[k]; i++)
      bits.push_back(d[(P_MSB[k] != 0) ? P_DW[k] - 1 - i : i]);
    p = (P_PO[k] != 0);
    for (int i = 0; i < P_DW[k]; i++) p = p ^ d[i];
    if (P_PE[k] != 0) bits.push_back(p);
    for (int i = 0; i < P_SB[k]; i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < P_CD[k]; c++) begin
        e.serial = bits[b];
        e.busy   = 1'b1;
        e.strobe = (c == P_CD[k] - 1);
        e.ready  = (b == bits.size() - 1) && (c == P_CD[k] - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_cycle(input int k, input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " serial"}, 32'(serial[k]),   32'(e.serial));
      check({tag, " busy"},   32'(busy[k]),     32'(e.busy));
      check({tag, " strobe"}, 32'(strobe[k]),   32'(e.strobe));
      check({tag, " ready"},  32'(tx_ready[k]), 32'(e.ready));
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, " idle serial"}, 32'(serial[k]),   32'd1);
    check({tag, " idle busy"},   32'(busy[k]),     32'd0);
    check({tag, " idle strobe"}, 32'(strobe[k]),   32'd0);
    check({tag, " idle ready"},  32'(tx_ready[k]), 32'd1);
  endtask

  task automatic send_frame(input int k, input logic [31:0] d, input bit toggle, input string tag);
    int f;
    f = flen(k);
    tx_data[k]  = d;
    tx_valid[k] = 1'b1;
    push_frame(k, d);
    tick();
    tx_valid[k] = 1'b0;
    for (int i = 0; i < f; i++) begin
      check_cycle(k, tag);
      if (toggle) tx_data[k] = $urandom;
      tick();
    end
    check_idle(k, tag);
  endtask

  initial begin
    int f;
    int pulses;

    rst      = 1'b1;
    tx_valid = '0;
    for (int k = 0; k < NDUT; k++) tx_data[k] = '0;
    tx_valid[0] = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < NDUT; k++) begin
      check("reset serial", 32'(serial[k]),   32'd1);
      check("reset busy",   32'(busy[k]),     32'd0);
      check("reset strobe", 32'(strobe[k]),   32'd0);
      check("reset ready",  32'(tx_ready[k]), 32'd0);
    end
    tx_valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) check("post-reset ready", 32'(tx_ready[k]), 32'd1);
    tick();

    send_frame(0, 32'hA5, 1'b0, "lsb A5");
    send_frame(1, 32'h07, 1'b0, "msb even 07");
    send_frame(1, 32'hA5, 1'b0, "msb even A5");
    send_frame(3, 32'h07, 1'b0, "odd 07");
    send_frame(3, 32'hFF, 1'b0, "odd FF");

    // Back-to-back frames with Tx_Valid held high.
    f = flen(0);
    pulses = 0;
    tx_data[0]  = 32'h01;
    tx_valid[0] = 1'b1;
    push_frame(0, 32'h01);
    push_frame(0, 32'h80);
    tick();
    tx_data[0] = 32'h80;
    for (int i = 0; i < 2 * f; i++) begin
      check_cycle(0, "b2b");
      if (tx_ready[0]) pulses++;
      if (i == f) tx_valid[0] = 1'b0;
      tick();
    end
    check("b2b ready pulses", 32'(pulses), 32'd2);
    check_idle(0, "b2b");

    // Reset in the middle of data bit 3, with a word offered at the same time.
    tx_data[0]  = 32'h00;
    tx_valid[0] = 1'b1;
    push_frame(0, 32'h00);
    tick();
    tx_valid[0] = 1'b0;
    for (int i = 0; i < 19; i++) begin
      check_cycle(0, "pre-abort");
      if (i == 18) begin
        rst         = 1'b1;
        tx_valid[0] = 1'b1;
        tx_data[0]  = 32'hFF;
      end
      tick();
    end
    exp_q.delete();
    check("abort serial", 32'(serial[0]),   32'd1);
    check("abort busy",   32'(busy[0]),     32'd0);
    check("abort ready",  32'(tx_ready[0]), 32'd0);
    tick();
    check("reset+valid busy", 32'(busy[0]),   32'd0);
    check("reset+valid serial", 32'(serial[0]), 32'd1);
    tx_valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("after abort ready", 32'(tx_ready[0]), 32'd1);
    tick();
    send_frame(0, 32'h3C, 1'b0, "after abort 3C");

    send_frame(2, 32'hFFF, 1'b0, "div1 FFF");
    send_frame(2, 32'h5A3, 1'b0, "div1 5A3");
    send_frame(0, 32'h5A, 1'b1, "toggle 5A");
    send_frame(3, 32'hC4, 1'b1, "toggle odd C4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
